// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- multiplexed seven-segment (plus DP) scan controller.
//
// The digits are scanned one slot at a time. Each slot lasts SCAN_COUNT+1
// clocks. The first BLANK_CYCLES clocks of every slot stay dark, which stops
// the previous digit's pattern from ghosting onto the next digit. Brightness
// comes from a free-running 4-bit PWM counter that is compared against
// `bright`. Segment patterns are captured into a shadow register once per
// frame, so a digit never changes partway through a frame.
//
// Ports
//   clk          system clock; all logic runs on the rising edge
//   rstn         asynchronous active-low reset
//   seg_data_in  DIGITS*8 segment patterns; byte k is digit k; 1 = lit
//   digit_en     per-digit enable; 0 keeps that digit dark for its slot
//   bright       brightness, 0 = minimum, 15 = full on
//   seg_sel      registered digit select, physical polarity (SEL_ACTIVE_LOW)
//   seg_data     registered segment drive, physical polarity (SEG_ACTIVE_LOW)
//   frame_tick   one-cycle pulse in the cycle after the shadow load
module seg_scan_ctrl #(
  parameter int CLK_FREQ       = 50000000,
  parameter int SCAN_FREQ      = 200,
  parameter int DIGITS         = 6,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DIGITS*8-1:0]   seg_data_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     seg_sel,
  output logic [7:0]            seg_data,
  output logic                  frame_tick
);

  localparam int SCAN_COUNT = CLK_FREQ / (SCAN_FREQ * DIGITS) - 1;
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [31:0]       SCAN_LAST   = 32'(SCAN_COUNT);
  localparam logic [31:0]       BLANK_START = 32'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF     = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF     = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  // Illegal parameter sets are rejected while the design is elaborated.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_ctrl: DIGITS must be in 1..8");
  end
  if (SCAN_COUNT <= BLANK_CYCLES) begin : g_bad_scan
    $error("seg_scan_ctrl: SCAN_COUNT must exceed BLANK_CYCLES");
  end

  logic [31:0]       timer;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        pwm_cnt;
  logic [7:0]        shadow [DIGITS];

  logic              slot_end;
  logic              frame_end;
  logic              lit;
  logic [DIGITS-1:0] sel_onehot;
  logic [7:0]        cur_byte;
  logic [DIGITS-1:0] sel_next;
  logic [7:0]        seg_next;

  always_comb begin
    slot_end   = (timer == SCAN_LAST);
    // The last clock of the last digit is where the next frame's patterns
    // are captured.
    frame_end  = slot_end && (idx == IDX_LAST);
    lit        = (timer >= BLANK_START) && digit_en[idx] && (pwm_cnt <= bright);
    sel_onehot = '0;
    sel_onehot[idx] = 1'b1;
    cur_byte   = shadow[idx];
    sel_next   = SEL_OFF;
    seg_next   = SEG_OFF;
    if (lit) begin
      sel_next = SEL_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
      seg_next = SEG_ACTIVE_LOW ? ~cur_byte : cur_byte;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer      <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      frame_tick <= 1'b0;
      seg_sel    <= SEL_OFF;
      seg_data   <= SEG_OFF;
      for (int k = 0; k < DIGITS; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (slot_end) begin
        timer <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        timer <= timer + 32'd1;
      end
      if (frame_end) begin
        for (int k = 0; k < DIGITS; k++) begin
          shadow[k] <= seg_data_in[8*k +: 8];
        end
      end
      frame_tick <= frame_end;
      seg_sel    <= sel_next;
      seg_data   <= seg_next;
    end
  end

endmodule
